warp_scheduler: RTL and testbench
=================================

// Module: warp_scheduler
// PURPOSE
//   Decides which warp owns the shared fetch/decode/execute pipeline each cycle and drives warp_select into the
//   warp_controller that sits directly downstream, which banks and restores per-warp PC/state. Switches on
//   memory stall, warp completion, or time-slice expiry, using round-robin order. Holds the shared pipeline for
//   one cycle per switch while the controller's registered swap completes. Reports kernel-level all_done.
// PARAMETERS
//   NUM_WARPS  2  number of warps sharing one core pipeline (>=2)
//   QUANTUM    16 max cycles a warp keeps the pipeline before a voluntary switch; 0 disables time-slicing
//   WB         max(1,$clog2(NUM_WARPS))  localparam, width of warp_select
// PORTS
//   clk               in   1          core clock
//   reset             in   1          asynchronous, active-low reset
//   start             in   1          kernel start pulse from dispatcher; sampled only in IDLE
//   warp_enable       in   NUM_WARPS  warp has nonzero thread_count for this block
//   warp_done         in   NUM_WARPS  per-warp done, as banked by warp_controller
//   warp_mem_pending  in   NUM_WARPS  warp has an LSU request outstanding (any thread LSU not IDLE/DONE)
//   core_state        in   3          live state of shared pipeline (IDLE..DONE, 3'b000..3'b111; WAIT=3'b100, UPDATE=3'b110)
//   warp_select       out  WB         index of warp owning the pipeline
//   hold              out  1          stall shared pipeline (no state advance) this cycle
//   switch_pulse      out  1          one-cycle pulse on the cycle warp_select changes
//   all_done          out  1          every enabled warp done
// BEHAVIOUR
//   Reset (async assert, sync deassert handled upstream): state=IDLE, warp_select=0, hold=1, switch_pulse=0,
//     all_done=0, quantum counter=0. Reset mid-operation aborts immediately, no draining.
//   ready[i] = warp_enable[i] & ~warp_done[i] & ~warp_mem_pending[i]; current warp excluded from candidate set.
//   next = first ready index after warp_select, wrapping modulo NUM_WARPS (round-robin).
//   States:
//   IDLE   hold=1. start & |warp_enable -> warp_select=lowest enabled index, RUN. start & ~|warp_enable -> DONE.
//   RUN    hold=0; qcnt increments (saturating at QUANTUM). Priority of switch causes, evaluated each cycle:
//          1) warp_done[cur] | core_state==DONE: all enabled warps done -> DONE; else any ready -> SWITCH to next;
//             else -> PARK.
//          2) core_state==WAIT & any ready -> SWITCH to next.
//          3) QUANTUM!=0 & qcnt>=QUANTUM & core_state==UPDATE & any ready -> SWITCH to next.
//          Otherwise remain in RUN on same warp.
//   SWITCH entered with warp_select<=next and switch_pulse=1 in same cycle; exactly 1 cycle, hold=1, qcnt<=0;
//          then RUN. Switch-to-run latency: 1 cycle of hold.
//   PARK   hold=1; all enabled done -> DONE; any non-done warp ready (current included) -> SWITCH to it
//          (switch_pulse only if index differs).
//   DONE   hold=1, all_done=1, sticky until reset; start ignored.
//   start outside IDLE ignored. Disabled warps never selected. Simultaneous WAIT and quantum expiry: one switch only.
//   warp_select only changes on SWITCH entry or IDLE->RUN; stable otherwise.
// STRUCTURE
//   gpu_pkg: core_state_t enum (IDLE,FETCH,DECODE,REQUEST,WAIT,EXECUTE,UPDATE,DONE), sched_state_t enum
//     (IDLE,RUN,SWITCH,PARK,DONE).
//   Sub-module rr_arbiter #(N): combinational round-robin picker (req vector, last index) -> (grant index, valid).
//   Top holds FSM, quantum counter and output registers; all outputs registered.
// TESTING
//   1) NUM_WARPS=2, both enabled, start; warp0 hits core_state=WAIT with warp1 ready -> SWITCH: hold=1 one cycle,
//      switch_pulse=1, warp_select 0->1.
//   2) QUANTUM=4, no stalls: switch occurs on first UPDATE after qcnt>=4; QUANTUM=0: no switch until done.
//   3) warp0 done while warp1 mem_pending=1 -> PARK (hold=1); mem_pending drops -> SWITCH to 1 then RUN.
//   4) warp_enable=2'b10, start -> warp_select=1 immediately, never 0; warp_enable=0, start -> all_done=1.
//   5) Both warps done -> DONE, all_done=1 sticky; further start ignored; reset low mid-RUN -> all outputs
//      to reset values same cycle.
//   6) NUM_WARPS=4, warps 1,3 ready at switch from warp 3 -> picks 1 (wrap-around round-robin).

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types for the warp scheduling slice of the core.
//   core_state_t  : live state of the shared fetch/decode/execute pipeline.
//   sched_state_t : warp_scheduler FSM states (also exported on its debug port).
// Both enums carry prefixes so they can live in one package without
// their literals colliding.
package gpu_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  typedef enum logic [2:0] {
    SCHED_IDLE   = 3'd0,
    SCHED_RUN    = 3'd1,
    SCHED_SWITCH = 3'd2,
    SCHED_PARK   = 3'd3,
    SCHED_DONE   = 3'd4
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   i_req   : request vector, one bit per index
//   i_last  : index that was granted last; the search starts just after it
//   o_grant : first requesting index after i_last, wrapping modulo N
//   o_valid : at least one request is set
// i_last itself is the final candidate searched, so if the caller leaves
// its own bit set in i_req it is chosen only when nothing else requests.
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_grant,
  output logic         o_valid
);

  logic [W-1:0] w_idx;

  // Walk from the farthest offset to the nearest so the nearest requester
  // is the last assignment and therefore wins.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int off = N; off >= 1; off--) begin
      w_idx = W'((int'(i_last) + off) % N);
      if (i_req[w_idx]) begin
        o_grant = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Decides which warp owns the shared core pipeline and drives warp_select
// into the downstream warp_controller. Switches round-robin on memory
// stall (WAIT), warp completion, or time-slice expiry at UPDATE.
//
// Ports:
//   clk              core clock
//   reset            asynchronous active-low reset
//   start            kernel start pulse, sampled only in IDLE
//   warp_enable      per-warp: warp has threads in this block
//   warp_done        per-warp done as banked by the controller
//   warp_mem_pending per-warp: LSU request outstanding
//   core_state       live state of the shared pipeline
//   warp_select      warp owning the pipeline
//   hold             pipeline must not advance this cycle
//   switch_pulse     one-cycle pulse when warp_select moves to a new warp
//   all_done         every enabled warp is done (sticky until reset)
//   dbg_state        scheduler FSM state
//
// Controller contract: switch_pulse and the new warp_select appear in the
// same cycle, always together with hold=1; the controller performs its
// registered bank/restore swap in that cycle and the pipeline resumes on
// the following RUN cycle. switch_pulse is not raised on IDLE->RUN because
// no warp context has been banked yet.
module warp_scheduler
  import gpu_pkg::*;
#(
  parameter  int NUM_WARPS = 2,
  parameter  int QUANTUM   = 16,
  localparam int WB        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_WARPS-1:0] warp_enable,
  input  logic [NUM_WARPS-1:0] warp_done,
  input  logic [NUM_WARPS-1:0] warp_mem_pending,
  input  logic [2:0]           core_state,
  output logic [WB-1:0]        warp_select,
  output logic                 hold,
  output logic                 switch_pulse,
  output logic                 all_done,
  output sched_state_t         dbg_state
);

  localparam int QW = (QUANTUM < 2) ? 1 : $clog2(QUANTUM + 1);

  sched_state_t   r_state;
  logic [WB-1:0]  r_sel;
  logic           r_hold;
  logic           r_pulse;
  logic           r_all_done;
  logic [QW-1:0]  r_qcnt;

  sched_state_t   w_nxt_state;
  logic [WB-1:0]  w_nxt_sel;
  logic           w_nxt_pulse;
  logic [QW-1:0]  w_qcnt_inc;

  logic [NUM_WARPS-1:0] w_ready;
  logic [NUM_WARPS-1:0] w_cand;
  logic                 w_all_done;
  logic                 w_cur_done;
  logic                 w_quantum_up;
  logic [WB-1:0]        w_run_next, w_park_next, w_first;
  logic                 w_run_valid, w_park_valid, w_first_valid;

  assign w_ready    = warp_enable & ~warp_done & ~warp_mem_pending;
  // In RUN the current warp is never a switch target.
  assign w_cand     = w_ready & ~(NUM_WARPS'(1) << r_sel);
  assign w_all_done = &(~warp_enable | warp_done);
  assign w_cur_done = warp_done[r_sel];
  assign w_quantum_up = (QUANTUM != 0) && (int'(r_qcnt) >= QUANTUM);
  assign w_qcnt_inc = (int'(r_qcnt) >= QUANTUM) ? r_qcnt : r_qcnt + QW'(1);

  // Switch target while running: current warp excluded.
  rr_arbiter #(.N(NUM_WARPS), .W(WB)) u_rr_run (
    .i_req(w_cand), .i_last(r_sel), .o_grant(w_run_next), .o_valid(w_run_valid)
  );

  // Resume target while parked: current warp allowed, searched last.
  rr_arbiter #(.N(NUM_WARPS), .W(WB)) u_rr_park (
    .i_req(w_ready), .i_last(r_sel), .o_grant(w_park_next), .o_valid(w_park_valid)
  );

  // Starting the search after the top index yields the lowest enabled warp.
  rr_arbiter #(.N(NUM_WARPS), .W(WB)) u_rr_first (
    .i_req(warp_enable), .i_last(WB'(NUM_WARPS - 1)), .o_grant(w_first), .o_valid(w_first_valid)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_sel   = r_sel;
    case (r_state)
      SCHED_IDLE: begin
        if (start) begin
          if (w_first_valid) begin
            w_nxt_state = SCHED_RUN;
            w_nxt_sel   = w_first;
          end else begin
            w_nxt_state = SCHED_DONE;
          end
        end
      end
      SCHED_RUN: begin
        // Completion outranks WAIT, which outranks quantum expiry, so a
        // coincident WAIT and expiry still yields a single switch.
        if (w_cur_done || core_state == CORE_DONE) begin
          if (w_all_done) begin
            w_nxt_state = SCHED_DONE;
          end else if (w_run_valid) begin
            w_nxt_state = SCHED_SWITCH;
            w_nxt_sel   = w_run_next;
          end else begin
            w_nxt_state = SCHED_PARK;
          end
        end else if (core_state == CORE_WAIT && w_run_valid) begin
          w_nxt_state = SCHED_SWITCH;
          w_nxt_sel   = w_run_next;
        end else if (w_quantum_up && core_state == CORE_UPDATE && w_run_valid) begin
          w_nxt_state = SCHED_SWITCH;
          w_nxt_sel   = w_run_next;
        end
      end
      SCHED_SWITCH: w_nxt_state = SCHED_RUN;
      SCHED_PARK: begin
        if (w_all_done) begin
          w_nxt_state = SCHED_DONE;
        end else if (w_park_valid) begin
          w_nxt_state = SCHED_SWITCH;
          w_nxt_sel   = w_park_next;
        end
      end
      SCHED_DONE: w_nxt_state = SCHED_DONE;
      default:    w_nxt_state = SCHED_IDLE;
    endcase
    // Resuming the parked warp itself is a hold cycle without a pulse.
    w_nxt_pulse = (w_nxt_state == SCHED_SWITCH) && (w_nxt_sel != r_sel);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= SCHED_IDLE;
      r_sel      <= '0;
      r_hold     <= 1'b1;
      r_pulse    <= 1'b0;
      r_all_done <= 1'b0;
      r_qcnt     <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_sel      <= w_nxt_sel;
      r_hold     <= (w_nxt_state != SCHED_RUN);
      r_pulse    <= w_nxt_pulse;
      r_all_done <= (w_nxt_state == SCHED_DONE);
      // The slice counts only consecutive RUN cycles of one warp.
      r_qcnt     <= (r_state == SCHED_RUN && w_nxt_state == SCHED_RUN) ? w_qcnt_inc : '0;
    end
  end

  assign warp_select  = r_sel;
  assign hold         = r_hold;
  assign switch_pulse = r_pulse;
  assign all_done     = r_all_done;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_warp_scheduler.sv
// Randomized bench for warp_scheduler. Two instances share the stimulus:
// dut0 (4 warps, quantum 4) and dut1 (2 warps, time-slicing off). A
// behavioural model computes the expected registered outputs for every
// clock; a monitor compares them one cycle later.
module tb_warp_scheduler;
  import gpu_pkg::*;

  localparam int M_IDLE = 0, M_RUN = 1, M_SWITCH = 2, M_PARK = 3, M_DONE = 4;
  localparam logic [4:0] RESET_OUT = 5'b00100; // {sel, hold, pulse, all_done}

  typedef struct {
    int st;
    int sel;
    int qcnt;
    bit pulse;
  } mdl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] en = '0, dn = '0, pend = '0;
  logic [2:0] cs = '0;

  logic [1:0]   sel0;
  logic         hold0, pulse0, done0;
  sched_state_t st0;
  logic [0:0]   sel1;
  logic         hold1, pulse1, done1;
  sched_state_t st1;

  logic [4:0] exp_q0[$];
  logic [4:0] exp_q1[$];
  mdl_t m0, m1;
  int checks = 0;
  int failures = 0;

  warp_scheduler #(.NUM_WARPS(4), .QUANTUM(4)) dut0 (
    .clk(clk), .reset(reset), .start(start), .warp_enable(en), .warp_done(dn),
    .warp_mem_pending(pend), .core_state(cs), .warp_select(sel0), .hold(hold0),
    .switch_pulse(pulse0), .all_done(done0), .dbg_state(st0)
  );

  warp_scheduler #(.NUM_WARPS(2), .QUANTUM(0)) dut1 (
    .clk(clk), .reset(reset), .start(start), .warp_enable(en[1:0]), .warp_done(dn[1:0]),
    .warp_mem_pending(pend[1:0]), .core_state(cs), .warp_select(sel1), .hold(hold1),
    .switch_pulse(pulse1), .all_done(done1), .dbg_state(st1)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int rr_pick(logic [3:0] mask, int cur, int n);
    for (int off = 1; off <= n; off++) begin
      if (mask[(cur + off) % n]) return (cur + off) % n;
    end
    return -1;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.st = M_IDLE; r.sel = 0; r.qcnt = 0; r.pulse = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int n, int q, bit s, logic [3:0] e,
                                    logic [3:0] d, logic [3:0] p, logic [2:0] c);
    mdl_t r = m;
    logic [3:0] rdy = '0;
    logic [3:0] cand;
    bit alldn = 1'b1;
    bit sw = 1'b0;
    int nx = -1;
    for (int i = 0; i < n; i++) begin
      rdy[i] = e[i] & ~d[i] & ~p[i];
      if (e[i] && !d[i]) alldn = 1'b0;
    end
    cand = rdy;
    cand[m.sel] = 1'b0;
    r.pulse = 1'b0;
    case (m.st)
      M_IDLE: if (s) begin
        nx = rr_pick(e, n - 1, n);
        if (nx < 0) r.st = M_DONE;
        else begin r.st = M_RUN; r.sel = nx; end
      end
      M_RUN: begin
        nx = rr_pick(cand, m.sel, n);
        if (d[m.sel] || c == 3'd7) begin
          if (alldn) r.st = M_DONE;
          else if (nx >= 0) sw = 1'b1;
          else r.st = M_PARK;
        end else if (c == 3'd4 && nx >= 0) sw = 1'b1;
        else if (q != 0 && m.qcnt >= q && c == 3'd6 && nx >= 0) sw = 1'b1;
      end
      M_SWITCH: r.st = M_RUN;
      M_PARK: begin
        if (alldn) r.st = M_DONE;
        else begin
          nx = rr_pick(rdy, m.sel, n);
          if (nx >= 0) sw = 1'b1;
        end
      end
      default: r.st = M_DONE;
    endcase
    if (sw) begin
      r.st = M_SWITCH;
      r.pulse = (nx != m.sel);
      r.sel = nx;
    end
    if (m.st == M_RUN && r.st == M_RUN) r.qcnt = (m.qcnt < q) ? m.qcnt + 1 : m.qcnt;
    else r.qcnt = 0;
    return r;
  endfunction

  function automatic logic [4:0] mdl_out(mdl_t m);
    return {2'(m.sel), m.st != M_RUN, m.pulse, m.st == M_DONE};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check5(string name, logic [4:0] act, logic [4:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s at %0t: got {sel,hold,pulse,done}=%b expected %b (dut0 st=%0d dut1 st=%0d)",
               name, $time, act, exp_v, st0, st1);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (exp_q0.size() > 0) check5("dut0_out", {sel0, hold0, pulse0, done0}, exp_q0.pop_front());
    if (exp_q1.size() > 0) check5("dut1_out", {1'b0, sel1, hold1, pulse1, done1}, exp_q1.pop_front());
  end

  // ---------------- driver ----------------
  // Advance both models with the inputs the DUTs will sample at the next
  // rising edge and queue the outputs they must show after it.
  task automatic step_and_push();
    if (!reset) begin
      m0 = mdl_reset();
      m1 = mdl_reset();
    end else begin
      m0 = mdl_step(m0, 4, 4, start, en, dn, pend, cs);
      m1 = mdl_step(m1, 2, 0, start, en, dn, pend, cs);
    end
    exp_q0.push_back(mdl_out(m0));
    exp_q1.push_back(mdl_out(m1));
  endtask

  task automatic randomize_inputs();
    int r;
    r = $urandom_range(0, 31);
    cs = (r == 0) ? 3'd7 : 3'(r % 7);
    for (int i = 0; i < 4; i++) begin
      pend[i] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) dn[i] = 1'b1;
    end
  endtask

  initial begin
    logic [3:0] k_en[10];
    int len;
    k_en = '{4'b0011, 4'b1010, 4'b0000, 4'b0100, 4'b1111,
             4'b0010, 4'b1001, 4'b0111, 4'b1110, 4'b0101};
    m0 = mdl_reset();
    m1 = mdl_reset();
    for (int k = 0; k < 10; k++) begin
      // Reset lands between edges: outputs must return to reset values
      // immediately, whatever the previous kernel was doing.
      @(negedge clk);
      reset = 1'b0; start = 1'b0; en = k_en[k]; dn = '0; pend = '0; cs = '0;
      #1;
      check5("async_reset_dut0", {sel0, hold0, pulse0, done0}, RESET_OUT);
      check5("async_reset_dut1", {1'b0, sel1, hold1, pulse1, done1}, RESET_OUT);
      step_and_push();
      repeat (2) begin
        @(negedge clk);
        step_and_push();
      end
      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      randomize_inputs();
      step_and_push();
      len = $urandom_range(40, 160);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        start = ($urandom_range(0, 15) == 0);
        randomize_inputs();
        step_and_push();
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left expected 0/0",
               exp_q0.size(), exp_q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
